dmem_dump: RTL

//  Host-side reader for the CPU data memory. Once the CPU has written its results
//  (puzzle states), walks a contiguous address range and streams each 40-bit word
//  out over a valid/ready interface. Shares the data memory's read port with the CPU.

---
 rtl/dmem_dump_if.sv | 31 +++
 rtl/dmem_dump.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dmem_dump_if.sv
// Bus bundle for dmem_dump: start/config, shared data-memory read port and output stream.
// slave = the dump engine, master = host/consumer side that also supplies memory data.
`timescale 1ns/1ps
interface dmem_dump_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 40
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic [DATA_W-1:0] mem_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_err;
   logic              busy;
   logic              done;

   modport slave (
      input  start, base_addr, count, mem_data, out_ready,
      output mem_addr, mem_re, out_valid, out_data, out_last, out_err, busy, done
   );

   modport master (
      output start, base_addr, count, mem_data, out_ready,
      input  mem_addr, mem_re, out_valid, out_data, out_last, out_err, busy, done
   );
endinterface

// File: rtl/dmem_dump.sv
// Streams a contiguous, wrapping address range of the CPU data memory out over valid/ready.
// Optional tile-permutation check on each word is enabled by defining PUZZLE_CHECK_EN.
`timescale 1ns/1ps
module dmem_dump #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 40
) (
   input  logic        clk,
   input  logic        rst_n,
   dmem_dump_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_r;
   logic [ADDR_W-1:0] cur_r;
   logic [ADDR_W:0]   rem_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic              mem_re_r;
   logic              out_valid_r;
   logic [DATA_W-1:0] out_data_r;
   logic              out_last_r;
   logic              out_err_r;
   logic              busy_r;
   logic              done_r;
   logic              last_word_s;
   logic              err_s;
   logic [ADDR_W-1:0] next_addr_s;

`ifdef PUZZLE_CHECK_EN
   // Nine 4-bit tiles must be exactly the set 0..8; any value above 8 or a repeat flags an error.
   function automatic logic puzzle_bad(input logic [35:0] tiles);
      logic [8:0] seen;
      logic       bad;
      logic [3:0] t;
      seen = 9'd0;
      bad  = 1'b0;
      for (int i = 0; i < 9; i++) begin
         t = tiles[4*i +: 4];
         if (t > 4'd8) begin
            bad = 1'b1;
         end else if (seen[t]) begin
            bad = 1'b1;
         end else begin
            seen[t] = 1'b1;
         end
      end
      return bad;
   endfunction

   assign err_s = puzzle_bad(bus.mem_data[35:0]);
`else
   assign err_s = 1'b0;
`endif

   assign last_word_s = (rem_r == (ADDR_W+1)'(1));
   assign next_addr_s = cur_r + ADDR_W'(1);

   // Dump sequencer; every output is a register updated on the transition into its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cur_r       <= {ADDR_W{1'b0}};
         rem_r       <= {(ADDR_W+1){1'b0}};
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_re_r    <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
         out_last_r  <= 1'b0;
         out_err_r   <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  busy_r <= 1'b1;
                  if (bus.count != {(ADDR_W+1){1'b0}}) begin
                     cur_r      <= bus.base_addr;
                     rem_r      <= bus.count;
                     mem_addr_r <= bus.base_addr;
                     mem_re_r   <= 1'b1;
                     state_r    <= FETCH;
                  end else begin
                     done_r  <= 1'b1;
                     state_r <= DONE;
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            FETCH: begin
               mem_re_r    <= 1'b0;
               out_data_r  <= bus.mem_data;
               out_last_r  <= last_word_s;
               out_err_r   <= err_s;
               out_valid_r <= 1'b1;
               state_r     <= SEND;
            end
            SEND: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  if (last_word_s) begin
                     done_r  <= 1'b1;
                     state_r <= DONE;
                  end else begin
                     cur_r      <= next_addr_s;
                     rem_r      <= rem_r - (ADDR_W+1)'(1);
                     mem_addr_r <= next_addr_s;
                     mem_re_r   <= 1'b1;
                     state_r    <= FETCH;
                  end
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               mem_re_r    <= 1'b0;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               done_r      <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_re    = mem_re_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_last  = out_last_r;
   assign bus.out_err   = out_err_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
endmodule
